// File: rtl/mux_sel_arbiter.sv
// ----------------------------------------------------------------------------
// mux_sel_arbiter
//
// Round-robin arbiter for four requesters that share one 4x1 mux path.
// It registers the winning requester's index onto sel, which drives the mux
// select input. It holds that grant until the owner releases it. All outputs
// come straight from flops, so sel never glitches.
//
// Parameters
//   MAX_HOLD  longest grant, in cycles, before a forced revoke (>= 2)
//   CNT_W     width of the hold counter; 2**CNT_W must exceed MAX_HOLD
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous, active-high reset
//   req        in   4  request per channel (bit0 -> din_a ... bit3 -> din_d)
//   rel        in   1  one-cycle pulse from the current owner that ends its
//                      grant ("release" is a reserved word in SystemVerilog)
//   sel        out  2  registered mux select
//   gnt        out  4  registered one-hot grant, 0 when idle
//   sel_valid  out  1  high while a grant is active
//   timeout    out  1  one-cycle pulse on a forced revoke
//
// Optional feature
//   ARB_TIMEOUT_EN  When this macro is defined, a grant is revoked after
//                   MAX_HOLD cycles without a release. When it is undefined,
//                   a grant lasts until rel and timeout is tied to 0.
// ----------------------------------------------------------------------------
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       rel,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       sel_valid,
  output logic       timeout
);

  // Reject a parameter set that would make the hold counter wrap
  // before it reaches the revoke point.
  if (!((MAX_HOLD >= 2) && ((2 ** CNT_W) > MAX_HOLD))) begin : g_cfg_err
    $error("mux_sel_arbiter: need MAX_HOLD >= 2 and 2**CNT_W > MAX_HOLD");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] last_ptr, last_ptr_nxt;
  logic [1:0] sel_nxt;
  logic [3:0] gnt_nxt;
  logic       valid_nxt;

  // A grant ends when the owner releases it or the hold timer expires.
  logic       revoke;

  // --------------------------------------------------------------------------
  // Round-robin pick. Scan starts one past the last owner and wraps mod 4.
  // The last owner is therefore checked last, so a lone requester still wins.
  // --------------------------------------------------------------------------
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    winner = 2'd0;
    cand   = 2'd0;
    found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_ptr + 2'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  // --------------------------------------------------------------------------
  // Hold timer. It stays at 0 in IDLE, so it is already clear on entry to
  // GRANT. In GRANT it counts the cycles the grant has been held. At
  // MAX_HOLD-1 the next edge ends the grant, so a grant never lasts more
  // than MAX_HOLD cycles.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] hold_cnt;
  logic             expire;
  logic             timeout_nxt;

  assign expire = (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign revoke = rel || expire;

  // If rel arrives in the expiry cycle, it counts as a normal release and
  // timeout stays low.
  assign timeout_nxt = (state == GRANT) && expire && !rel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= timeout_nxt;
      if (state == GRANT && !revoke) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end else begin
        hold_cnt <= '0;
      end
    end
  end
`else
  assign revoke  = rel;
  assign timeout = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic and next-output logic.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    gnt_nxt      = gnt;
    valid_nxt    = sel_valid;
    last_ptr_nxt = last_ptr;

    case (state)
      // Release is ignored here. Each grant drops back to IDLE for at least
      // one cycle, so grants are never back to back.
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          sel_nxt   = winner;
          gnt_nxt   = 4'b0001 << winner;
          valid_nxt = 1'b1;
        end
      end

      // Changes on req are ignored here, including the owner dropping its
      // request. Only a revoke ends the grant. sel is left alone so the mux
      // path does not switch until the next winner is chosen.
      GRANT: begin
        if (revoke) begin
          state_nxt    = IDLE;
          gnt_nxt      = 4'b0000;
          valid_nxt    = 1'b0;
          last_ptr_nxt = sel;
        end
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers. last_ptr resets to 3, so channel 0 has first
  // priority.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments. All flops then
    // sample values from before the edge, whatever order the simulator runs
    // the blocks in.
    if (rst) begin
      state     <= IDLE;
      sel       <= 2'b00;
      gnt       <= 4'b0000;
      sel_valid <= 1'b0;
      last_ptr  <= 2'b11;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      gnt       <= gnt_nxt;
      sel_valid <= valid_nxt;
      last_ptr  <= last_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux_sel_arbiter
//
// Scoreboard bench for mux_sel_arbiter. The driver applies req/rel on the
// falling edge. A reference model then works out what the outputs must be
// after the next rising edge and pushes that into a queue. The monitor
// samples the outputs 1 time unit after each rising edge, pops one entry and
// compares it with the outputs.
// Define ARB_TIMEOUT_EN for both the bench and the RTL to cover the timeout
// build.
// ----------------------------------------------------------------------------
module tb_mux_sel_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 3;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       rel = 1'b0;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       sel_valid;
  logic       timeout;

  always #5 clk = ~clk;

  mux_sel_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rel       (rel),
    .sel       (sel),
    .gnt       (gnt),
    .sel_valid (sel_valid),
    .timeout   (timeout)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       valid;
    logic       to;
  } obs_t;

  obs_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "reset";

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got sel=%0d gnt=%b valid=%b timeout=%b, want sel=%0d gnt=%b valid=%b timeout=%b",
               name, $time, act.sel, act.gnt, act.valid, act.to,
               exp.sel, exp.gnt, exp.valid, exp.to);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model, written in terms of who owns the mux. m_owner is -1 when
  // nobody holds a grant.
  // --------------------------------------------------------------------------
  int m_owner, m_last, m_sel, m_hold;
  bit m_to;

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_sel   = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic rl);
    int c;
    m_to = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (r[c]) begin
          m_owner = c;
          m_sel   = c;
          m_hold  = 1;
          break;
        end
      end
    end else if (rl) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (TO_EN && m_hold >= MAX_HOLD) begin
      m_last  = m_owner;
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_hold++;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.sel   = 2'(m_sel);
    o.gnt   = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    o.valid = (m_owner >= 0);
    o.to    = m_to;
    return o;
  endfunction

  task automatic drive(input logic [3:0] r, input logic rl);
    @(negedge clk);
    req = r;
    rel = rl;
    model_step(r, rl);
    exp_q.push_back(model_obs());
  endtask

  // Monitor
  always @(posedge clk) begin
    obs_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(phase, {sel, gnt, sel_valid, timeout}, e);
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #12;
    check("reset_initial", {sel, gnt, sel_valid, timeout}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-grant on channel 2, then all four request: ch0 first.
    phase = "reset_mid_grant";
    drive(4'b0100, 1'b0);
    drive(4'b0000, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("reset_async", {sel, gnt, sel_valid, timeout}, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    phase = "after_reset_ch0";
    drive(4'b1111, 1'b0);
    drive(4'b1111, 1'b1);

    // All four requesting, prompt release: grants rotate 1,2,3,0,1 with one
    // idle cycle between grants.
    phase = "rotate_all";
    for (int g = 0; g < 5; g++) begin
      drive(4'b1111, 1'b0);
      drive(4'b1111, 1'b0);
      drive(4'b1111, 1'b1);
    end
    drive(4'b0000, 1'b0);

    // Wrap: ch1 releases (last_ptr=1), then req=0011 -> ch0.
    phase = "wrap";
    drive(4'b0010, 1'b0);
    drive(4'b0000, 1'b1);
    drive(4'b0011, 1'b0);
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b0);

    // Owner drops its request without releasing. The release lands on the
    // expiry cycle, and a second release arrives while IDLE.
    phase = "drop_req";
    drive(4'b0100, 1'b0);
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b0);

    // Lone requester re-wins after its own release.
    phase = "lone_rewin";
    drive(4'b1000, 1'b0);
    drive(4'b1000, 1'b1);
    drive(4'b1000, 1'b0);
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b0);

    // No release for a long time: timeout after MAX_HOLD cycles when the
    // feature is enabled, otherwise the grant is held indefinitely.
    phase = "long_hold";
    drive(4'b0001, 1'b0);
    for (int k = 0; k < 100; k++) drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b0);

    // Randomized traffic.
    phase = "random";
    for (int k = 0; k < 400; k++) begin
      drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b0);

    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
